tinyalu_scheduler: RTL

Round-robin scheduler that shares one TinyALU datapath between NUM_REQ independent command sources. It sits between the requesters and the ALU's A/B/op/start/done/result pins. Each accepted command is issued to the ALU with start held until done. The scheduler returns the 16-bit result tagged with the requester index.

---
 rtl/tinyalu_sched_pkg.sv | 14 +
 rtl/tinyalu_rr_grant.sv | 28 ++
 rtl/tinyalu_scheduler.sv | 107 ++++++++++
 3 files changed

// File: rtl/tinyalu_sched_pkg.sv
// tinyalu_sched_pkg: shared state, opcode and command types for the TinyALU scheduler
package tinyalu_sched_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;
  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
  } cmd_t;
endpackage

// File: rtl/tinyalu_rr_grant.sv
// tinyalu_rr_grant: combinational round-robin pick of the first request at or after the pointer
module tinyalu_rr_grant #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);
  logic [IW-1:0] w_j;
  // scan from the farthest offset back to the pointer so the nearest valid requester wins
  always_comb begin
    o_grant = '0;
    o_idx = '0;
    w_j = '0;
    for (int k = N - 1; k >= 0; k--) begin
      w_j = IW'((int'(i_ptr) + k) % N);
      if (i_req[w_j]) begin
        o_grant = '0;
        o_grant[w_j] = 1'b1;
        o_idx = w_j;
      end
    end
  end
  assign o_any = |i_req;
endmodule

// File: rtl/tinyalu_scheduler.sv
// tinyalu_scheduler: round-robin sharing of one TinyALU between NUM_REQ requesters; optional watchdog via TINYALU_SCHED_WATCHDOG_EN
module tinyalu_scheduler
  import tinyalu_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT_CYCLES = 15,
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [8*NUM_REQ-1:0] req_a,
  input  logic [8*NUM_REQ-1:0] req_b,
  input  logic [3*NUM_REQ-1:0] req_op,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IW-1:0]        rsp_id,
  output logic [15:0]          rsp_result,
  output logic                 rsp_error,
  output logic [7:0]           alu_a,
  output logic [7:0]           alu_b,
  output logic [2:0]           alu_op,
  output logic                 alu_start,
  input  logic                 alu_done,
  input  logic [15:0]          alu_result
);
  state_t r_state, w_next;
  cmd_t r_cmd, w_cmd;
  logic [IW-1:0] r_ptr, r_id, w_idx;
  logic [NUM_REQ-1:0] w_grant;
  logic w_any, w_accept, w_expire, r_start, r_rsp_valid;
  logic [15:0] r_result;

  tinyalu_rr_grant #(.N(NUM_REQ)) u_grant (
    .i_req(req_valid),
    .i_ptr(r_ptr),
    .o_grant(w_grant),
    .o_idx(w_idx),
    .o_any(w_any)
  );

  assign w_cmd = '{a: req_a[8*w_idx +: 8], b: req_b[8*w_idx +: 8], op: req_op[3*w_idx +: 3]};
  assign w_accept = (r_state == IDLE) && w_any;

  // next state and the combinational accept strobe; a NOP skips the ALU entirely
  always_comb begin
    req_ready = (r_state == IDLE) ? w_grant : '0;
    w_next = (r_state == IDLE) ? (w_any ? ((w_cmd.op == OP_NOP) ? RESP : ISSUE) : IDLE) :
             (r_state == ISSUE) ? ((alu_done || w_expire) ? RESP : ISSUE) :
             (rsp_ready ? IDLE : RESP);
  end

  // state, registered ALU/response outputs, command capture and pointer advance
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_ptr <= '0;
      r_cmd <= '0;
      r_id <= '0;
      r_result <= '0;
      r_start <= 1'b0;
      r_rsp_valid <= 1'b0;
    end else begin
      r_state <= w_next;
      r_start <= (w_next == ISSUE);
      r_rsp_valid <= (w_next == RESP);
      if (w_accept) begin
        r_cmd <= w_cmd;
        r_id <= w_idx;
        r_ptr <= (w_idx == IW'(NUM_REQ - 1)) ? '0 : w_idx + IW'(1);
        r_result <= '0;
      end
      if (r_state == ISSUE && alu_done) r_result <= alu_result;
    end
  end

  assign alu_start = r_start;
  assign alu_a = r_cmd.a;
  assign alu_b = r_cmd.b;
  assign alu_op = r_cmd.op;
  assign rsp_valid = r_rsp_valid;
  assign rsp_id = r_id;
  assign rsp_result = r_result;

`ifdef TINYALU_SCHED_WATCHDOG_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WW-1:0] r_wd;
  logic r_error;
  assign w_expire = (r_wd == WW'(TIMEOUT_CYCLES - 1));
  assign rsp_error = r_error;
  // count ISSUE cycles; expiry flags an error unless alu_done lands in the same cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wd <= '0;
      r_error <= 1'b0;
    end else begin
      r_wd <= (r_state == ISSUE && w_next == ISSUE) ? r_wd + WW'(1) : '0;
      if (w_accept) r_error <= 1'b0;
      else if (r_state == ISSUE && !alu_done && w_expire) r_error <= 1'b1;
    end
  end
`else
  assign w_expire = 1'b0;
  assign rsp_error = 1'b0;
`endif
endmodule
